mdr_mem_unit: RTL and testbench
===============================

# mdr_mem_unit

Parametrised memory data register with a memory-side handshake, sub-word loads/stores and timeout detection. It is the next generation of the CPU's MDR. The MDR can be loaded from the internal bus, or filled and drained through a request/acknowledge memory port with variable wait states. It sits between the datapath bus and the memory interface and drives the bus mux input for the MDR.

## Interface
Parameters:
- WIDTH, 32, data width; multiple of 8, at least 16.
- TIMEOUT, 15, maximum cycles to wait for mem_ack before aborting; at least 1.

Ports (OW = log2(WIDTH/8)):
- clock  in  1  single system clock; all state updates on the rising edge.
- clear  in  1  asynchronous, active-high reset.
- MDRin  in  1  load MDR from BusMuxOut (idle only).
- Read  in  1  start a memory load (idle only).
- Write  in  1  start a memory store (idle only).
- size  in  2  access size: 00 byte, 01 half, 10 full word, 11 reserved.
- Signed  in  1  sign-extend sub-word loads; 0 = zero-extend.
- offset  in  OW  byte offset of the access within the word.
- BusMuxOut  in  WIDTH  internal bus data.
- Mdatain  in  WIDTH  memory read data; valid when mem_ack is high.
- mem_ack  in  1  memory acknowledge; sampled only while mem_req is high.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = store, 0 = load.
- mem_be  out  WIDTH/8  byte enables.
- mem_wdata  out  WIDTH  store data, placed in its byte lanes.
- BusMuxInMDR  out  WIDTH  MDR contents.
- busy  out  1  high whenever the unit is not in IDLE.
- done  out  1  one-cycle pulse when an access completes.
- err  out  1  one-cycle pulse on a misaligned access, reserved size, or timeout.

## Operation
States: IDLE, RD_WAIT, WR_WAIT, RESP.

IDLE:
- Priority order: Read > Write > MDRin; only the highest-priority active input acts.
- MDRin loads BusMuxOut into the MDR on that edge.
- Legality check on Read/Write:
  - Illegal: size=11, a half access with odd offset, or a word access with nonzero offset.
  - An illegal Read/Write goes to RESP with err set; no mem_req is issued and the MDR is unchanged.
- Legal Read: go to RD_WAIT with mem_req=1, mem_we=0, mem_be set by size/offset.
- Legal Write: go to WR_WAIT with mem_req=1, mem_we=1.
  - mem_wdata holds the low byte/half/word of the MDR shifted to byte lane `offset`; unused lanes are 0.
  - mem_be matches the written lanes.
- Access attributes (size, Signed, offset, write data) are latched at the start and held stable until mem_req drops.

RD_WAIT:
- On mem_ack: extract the lanes from Mdatain, shift them to bit 0, extend per Signed, and load into the MDR. Go to RESP with done set.

WR_WAIT:
- On mem_ack: go to RESP with done set; the MDR is unchanged.

Wait counter and timeout:
- Counts cycles spent in RD_WAIT/WR_WAIT.
- If the counter reaches TIMEOUT with no ack: drop mem_req, go to RESP with err set; the MDR is unchanged.

RESP:
- Drives a one-cycle done or err pulse, then returns to IDLE.

Inputs outside IDLE:
- MDRin, Read and Write are ignored while not in IDLE.

Reset (clear high):
- MDR = 0, state = IDLE, counter = 0.
- mem_req, mem_we, mem_be, mem_wdata, done, err and busy all 0.
- Takes effect immediately, including mid-access; a late mem_ack after clear is ignored.

## Timing
- mem_req is registered: it rises on the edge after Read/Write is sampled.
- Minimum load latency:
  - Read sampled at edge 0.
  - mem_ack high in cycle 1: the MDR updates at edge 1.
  - done is high during cycle 2.
- mem_req falls on the edge where mem_ack is sampled; at most one ack is consumed per access.
- Timeout: with mem_req high for TIMEOUT cycles and no ack, mem_req falls at the next edge, with err the following cycle.
- If mem_ack arrives on the same edge the timeout fires, the ack wins.
- done and err are never high together.
- BusMuxInMDR reflects the register output with no combinational path from the inputs.

## Structure
- Package mdr_pkg:
  - Size encodings SZ_BYTE, SZ_HALF, SZ_WORD.
  - State enum.
  - Function for the legality check.
- Sub-module mdr_lane_align (combinational):
  - Load path: Mdatain, size, offset, Signed → aligned, extended word.
  - Store path: MDR, size, offset → mem_wdata and mem_be.
- Top level holds the FSM, wait counter and MDR register.

## Test plan
- Bus load: MDRin with BusMuxOut=0xDEADBEEF → BusMuxInMDR=0xDEADBEEF next cycle; mem_req stays 0.
- Signed byte load: size=00, offset=3, Signed=1, Mdatain=0x80FF1234, ack after 3 wait cycles → MDR=0xFFFFFF80; done is a single pulse, busy for 5 cycles.
- Half store: MDR=0x0000ABCD, size=01, offset=2 → mem_wdata=0xABCD0000, mem_be=1100, mem_we=1.
- Misaligned and reserved: word with offset=1, then size=11 → err pulse each time; no mem_req; MDR unchanged.
- Timeout: TIMEOUT=4, no ack → mem_req high exactly 4 cycles, then an err pulse; MDR keeps its prior value.
- Clear mid-read while in RD_WAIT → all outputs 0 asynchronously; a subsequent ack is ignored; a new Read works normally.

Source files
------------

// File: rtl/mdr_pkg.sv
// Shared encodings, FSM state type and access legality rule for the memory data register.
package mdr_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RD_WAIT = 2'b01,
        WR_WAIT = 2'b10,
        RESP    = 2'b11
    } state_t;

    // Halves must be 2-byte aligned and full words must sit at lane 0.
    function automatic logic access_legal(input logic [1:0] sz, input logic [7:0] off);
        logic ok;
        case (sz)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~off[0];
            SZ_WORD: ok = (off == 8'd0);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mdr_lane_align.sv
// Byte-lane steering: extracts/extends load data and positions store data with byte enables.
module mdr_lane_align
    import mdr_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [1:0]                   ld_size,
    input  logic                         ld_signed,
    input  logic [$clog2(WIDTH/8)-1:0]   ld_offset,
    input  logic [WIDTH-1:0]             rdata,
    output logic [WIDTH-1:0]             ld_data_c,
    input  logic [1:0]                   st_size,
    input  logic [$clog2(WIDTH/8)-1:0]   st_offset,
    input  logic [WIDTH-1:0]             st_data,
    output logic [WIDTH-1:0]             st_wdata_c,
    output logic [WIDTH/8-1:0]           st_be_c
);

    localparam int unsigned NB = WIDTH / 8;

    logic [WIDTH-1:0] shifted;

    // Load: bring the addressed lanes down to bit 0, then extend.
    always_comb begin
        shifted = rdata >> {ld_offset, 3'b000};
        case (ld_size)
            SZ_BYTE: ld_data_c = {{(WIDTH-8){ld_signed & shifted[7]}}, shifted[7:0]};
            SZ_HALF: ld_data_c = {{(WIDTH-16){ld_signed & shifted[15]}}, shifted[15:0]};
            default: ld_data_c = shifted;
        endcase
    end

    // Store: move the low bytes of the MDR up to their lanes; unused lanes stay zero.
    always_comb begin
        case (st_size)
            SZ_BYTE: begin
                st_wdata_c = WIDTH'(st_data[7:0]) << {st_offset, 3'b000};
                st_be_c    = NB'(1) << st_offset;
            end
            SZ_HALF: begin
                st_wdata_c = WIDTH'(st_data[15:0]) << {st_offset, 3'b000};
                st_be_c    = NB'(3) << st_offset;
            end
            SZ_WORD: begin
                st_wdata_c = st_data;
                st_be_c    = '1;
            end
            default: begin
                st_wdata_c = '0;
                st_be_c    = '0;
            end
        endcase
    end

endmodule

// File: rtl/mdr_mem_unit.sv
// Memory data register with bus load, req/ack memory port, sub-word accesses and wait timeout.
module mdr_mem_unit
    import mdr_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                         clock,
    input  logic                         clear,
    input  logic                         MDRin,
    input  logic                         Read,
    input  logic                         Write,
    input  logic [1:0]                   size,
    input  logic                         Signed,
    input  logic [$clog2(WIDTH/8)-1:0]   offset,
    input  logic [WIDTH-1:0]             BusMuxOut,
    input  logic [WIDTH-1:0]             Mdatain,
    input  logic                         mem_ack,
    output logic                         mem_req,
    output logic                         mem_we,
    output logic [WIDTH/8-1:0]           mem_be,
    output logic [WIDTH-1:0]             mem_wdata,
    output logic [WIDTH-1:0]             BusMuxInMDR,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);

    localparam int unsigned NB = WIDTH / 8;
    localparam int unsigned OW = $clog2(NB);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  mdr_q, mdr_d;
    logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
    logic [1:0]        sz_q, sz_d;
    logic              sgn_q, sgn_d;
    logic [OW-1:0]     off_q, off_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [NB-1:0]     be_q, be_d;
    logic [WIDTH-1:0]  wdata_q, wdata_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;

    logic [WIDTH-1:0]  ld_data_c;
    logic [WIDTH-1:0]  st_wdata_c;
    logic [NB-1:0]     st_be_c;

    mdr_lane_align #(.WIDTH(WIDTH)) u_align (
        .ld_size    (sz_q),
        .ld_signed  (sgn_q),
        .ld_offset  (off_q),
        .rdata      (Mdatain),
        .ld_data_c  (ld_data_c),
        .st_size    (size),
        .st_offset  (offset),
        .st_data    (mdr_q),
        .st_wdata_c (st_wdata_c),
        .st_be_c    (st_be_c)
    );

    // State and registered outputs.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= IDLE;
            mdr_q   <= '0;
            cnt_q   <= '0;
            sz_q    <= '0;
            sgn_q   <= 1'b0;
            off_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mdr_q   <= mdr_d;
            cnt_q   <= cnt_d;
            sz_q    <= sz_d;
            sgn_q   <= sgn_d;
            off_q   <= off_d;
            req_q   <= req_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        mdr_d   = mdr_q;
        cnt_d   = cnt_q;
        sz_d    = sz_q;
        sgn_d   = sgn_q;
        off_d   = off_q;
        req_d   = req_q;
        we_d    = we_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        cnt_inc = cnt_q + CW'(1);

        case (state_q)
            IDLE: begin
                if (Read || Write) begin
                    if (!access_legal(size, 8'(offset))) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                    end else begin
                        state_d = Read ? RD_WAIT : WR_WAIT;
                        req_d   = 1'b1;
                        we_d    = ~Read;
                        be_d    = st_be_c;
                        wdata_d = Read ? '0 : st_wdata_c;
                        sz_d    = size;
                        sgn_d   = Signed;
                        off_d   = offset;
                        cnt_d   = '0;
                    end
                end else if (MDRin) begin
                    mdr_d = BusMuxOut;
                end
            end
            RD_WAIT, WR_WAIT: begin
                // An ack on the timeout edge still completes the access.
                if (mem_ack || cnt_inc == CW'(TIMEOUT)) begin
                    state_d = RESP;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    be_d    = '0;
                    wdata_d = '0;
                    cnt_d   = '0;
                    done_d  = mem_ack;
                    err_d   = ~mem_ack;
                    if (mem_ack && state_q == RD_WAIT) begin
                        mdr_d = ld_data_c;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign mem_req     = req_q;
    assign mem_we      = we_q;
    assign mem_be      = be_q;
    assign mem_wdata   = wdata_q;
    assign BusMuxInMDR = mdr_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_mdr_mem_unit.sv
// Directed bench for mdr_mem_unit: bus load, sub-word load/store, illegal access, timeout, clear.
module tb_mdr_mem_unit;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic        MDRin = 1'b0;
    logic        Read = 1'b0;
    logic        Write = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        Signed = 1'b0;
    logic [1:0]  offset = 2'b00;
    logic [31:0] BusMuxOut = '0;
    logic [31:0] Mdatain = '0;
    logic        mem_ack = 1'b0;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] BusMuxInMDR;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    mdr_mem_unit #(.WIDTH(32), .TIMEOUT(4)) dut (
        .clock       (clock),
        .clear       (clear),
        .MDRin       (MDRin),
        .Read        (Read),
        .Write       (Write),
        .size        (size),
        .Signed      (Signed),
        .offset      (offset),
        .BusMuxOut   (BusMuxOut),
        .Mdatain     (Mdatain),
        .mem_ack     (mem_ack),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_be      (mem_be),
        .mem_wdata   (mem_wdata),
        .BusMuxInMDR (BusMuxInMDR),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clock = ~clock;

    task automatic test_reset();
        repeat (2) @(negedge clock);
        checks++;
        if ({mem_req, mem_we, mem_be, mem_wdata, BusMuxInMDR, busy, done, err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got req=%b we=%b be=%b wdata=%h mdr=%h busy=%b done=%b err=%b, want all 0",
                     mem_req, mem_we, mem_be, mem_wdata, BusMuxInMDR, busy, done, err);
        end
        clear = 1'b0;
    endtask

    task automatic test_bus_load();
        @(negedge clock);
        MDRin = 1'b1;
        BusMuxOut = 32'hDEADBEEF;
        @(negedge clock);
        MDRin = 1'b0;
        checks++;
        if (BusMuxInMDR !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL bus_load_mdr: got %h want deadbeef", BusMuxInMDR);
        end
        checks++;
        if (mem_req !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bus_load_idle: got req=%b busy=%b want 0 0", mem_req, busy);
        end
    endtask

    task automatic test_signed_load();
        int busy_cnt = 0;
        int done_cnt = 0;
        int err_cnt = 0;
        @(negedge clock);
        Read = 1'b1; size = 2'b00; offset = 2'd3; Signed = 1'b1;
        Mdatain = 32'h80FF1234;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clock);
            Read = 1'b0;
            // Bus loads and new accesses during the wait must not act.
            MDRin = (c <= 3);
            Write = (c == 2);
            BusMuxOut = 32'h11111111;
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (err) err_cnt++;
            if (c == 1) begin
                checks++;
                if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_be !== 4'b1000) begin
                    errors++;
                    $display("FAIL sload_req: got req=%b we=%b be=%b want 1 0 1000", mem_req, mem_we, mem_be);
                end
            end
            if (c == 4) begin
                checks++;
                if (BusMuxInMDR !== 32'hDEADBEEF) begin
                    errors++;
                    $display("FAIL sload_ignore_mdrin: got %h want deadbeef", BusMuxInMDR);
                end
            end
            mem_ack = (c == 4);
        end
        MDRin = 1'b0;
        checks++;
        if (BusMuxInMDR !== 32'hFFFFFF80) begin
            errors++;
            $display("FAIL sload_mdr: got %h want ffffff80", BusMuxInMDR);
        end
        checks++;
        if (busy_cnt !== 5 || done_cnt !== 1 || err_cnt !== 0) begin
            errors++;
            $display("FAIL sload_pulses: got busy=%0d done=%0d err=%0d want 5 1 0", busy_cnt, done_cnt, err_cnt);
        end
    endtask

    task automatic test_half_store();
        @(negedge clock);
        MDRin = 1'b1; BusMuxOut = 32'h0000ABCD;
        @(negedge clock);
        MDRin = 1'b0;
        Write = 1'b1; size = 2'b01; offset = 2'd2; Signed = 1'b0;
        @(negedge clock);
        Write = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'b1100 || mem_wdata !== 32'hABCD0000) begin
            errors++;
            $display("FAIL hstore_req: got req=%b we=%b be=%b wdata=%h want 1 1 1100 abcd0000",
                     mem_req, mem_we, mem_be, mem_wdata);
        end
        mem_ack = 1'b1;
        Mdatain = 32'h55555555;
        @(negedge clock);
        mem_ack = 1'b0;
        checks++;
        if (done !== 1'b1 || err !== 1'b0 || mem_req !== 1'b0 || BusMuxInMDR !== 32'h0000ABCD) begin
            errors++;
            $display("FAIL hstore_done: got done=%b err=%b req=%b mdr=%h want 1 0 0 0000abcd",
                     done, err, mem_req, BusMuxInMDR);
        end
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL hstore_idle: got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_illegal();
        logic [1:0] sz_v  [3] = '{2'b10, 2'b11, 2'b01};
        logic [1:0] off_v [3] = '{2'd1, 2'd0, 2'd1};
        logic       rd_v  [3] = '{1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            Read = rd_v[i]; Write = ~rd_v[i]; size = sz_v[i]; offset = off_v[i];
            @(negedge clock);
            Read = 1'b0; Write = 1'b0;
            checks++;
            if (err !== 1'b1 || done !== 1'b0 || mem_req !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL illegal_%0d_err: got err=%b done=%b req=%b busy=%b want 1 0 0 1",
                         i, err, done, mem_req, busy);
            end
            @(negedge clock);
            checks++;
            if (err !== 1'b0 || busy !== 1'b0 || BusMuxInMDR !== 32'h0000ABCD) begin
                errors++;
                $display("FAIL illegal_%0d_after: got err=%b busy=%b mdr=%h want 0 0 0000abcd",
                         i, err, busy, BusMuxInMDR);
            end
        end
    endtask

    task automatic test_timeout();
        int req_cnt = 0;
        int err_cnt = 0;
        int err_at = 0;
        @(negedge clock);
        Read = 1'b1; size = 2'b10; offset = 2'd0;
        Mdatain = 32'h99999999;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clock);
            Read = 1'b0;
            if (mem_req) req_cnt++;
            if (err) begin err_cnt++; err_at = c; end
        end
        checks++;
        if (req_cnt !== 4 || err_cnt !== 1 || err_at !== 5) begin
            errors++;
            $display("FAIL timeout_timing: got req_cycles=%0d err_count=%0d err_cycle=%0d want 4 1 5",
                     req_cnt, err_cnt, err_at);
        end
        checks++;
        if (BusMuxInMDR !== 32'h0000ABCD || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_mdr: got mdr=%h busy=%b want 0000abcd 0", BusMuxInMDR, busy);
        end
    endtask

    task automatic test_ack_at_timeout();
        int done_cnt = 0;
        int err_cnt = 0;
        @(negedge clock);
        Read = 1'b1; size = 2'b01; offset = 2'd2; Signed = 1'b0;
        Mdatain = 32'h87654321;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clock);
            Read = 1'b0;
            if (done) done_cnt++;
            if (err) err_cnt++;
            mem_ack = (c == 4);
        end
        checks++;
        if (done_cnt !== 1 || err_cnt !== 0) begin
            errors++;
            $display("FAIL ack_at_timeout_pulse: got done=%0d err=%0d want 1 0", done_cnt, err_cnt);
        end
        checks++;
        if (BusMuxInMDR !== 32'h00008765) begin
            errors++;
            $display("FAIL ack_at_timeout_mdr: got %h want 00008765", BusMuxInMDR);
        end
    endtask

    task automatic test_clear_mid_read();
        @(negedge clock);
        Read = 1'b1; size = 2'b10; offset = 2'd0;
        @(negedge clock);
        Read = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL clear_pre: got req=%b busy=%b want 1 1", mem_req, busy);
        end
        #2 clear = 1'b1;
        #1;
        checks++;
        if ({mem_req, mem_we, mem_be, mem_wdata, BusMuxInMDR, busy, done, err} !== '0) begin
            errors++;
            $display("FAIL clear_async: got req=%b be=%b mdr=%h busy=%b want all 0",
                     mem_req, mem_be, BusMuxInMDR, busy);
        end
        mem_ack = 1'b1;
        Mdatain = 32'h12345678;
        @(negedge clock);
        clear = 1'b0;
        @(negedge clock);
        mem_ack = 1'b0;
        checks++;
        if (BusMuxInMDR !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL clear_late_ack: got mdr=%h busy=%b done=%b want 0 0 0", BusMuxInMDR, busy, done);
        end
        Read = 1'b1; size = 2'b10; offset = 2'd0;
        @(negedge clock);
        Read = 1'b0;
        mem_ack = 1'b1;
        Mdatain = 32'hCAFEF00D;
        @(negedge clock);
        mem_ack = 1'b0;
        checks++;
        if (done !== 1'b1 || BusMuxInMDR !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL clear_new_read: got done=%b mdr=%h want 1 cafef00d", done, BusMuxInMDR);
        end
    endtask

    initial begin
        test_reset();
        test_bus_load();
        test_signed_load();
        test_half_store();
        test_illegal();
        test_timeout();
        test_ack_at_timeout();
        test_clear_mid_read();
        repeat (2) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
